clk_power_seq: RTL

- Power/clock sequencer for the external clock generator: drives its OSC_ENA and CLK_ENA inputs and holds the CPU in reset until the oscillator is qualified stable.
- Also sequences STOP-mode entry and wake-up: the clock is gated on a machine-cycle boundary, the oscillator is shut down, and restart on WAKE skips the CPU reset.
- Sits between the reset pad / CPU STOP decode and the clock generator. Moore machine on a registered state; all outputs are decoded from the state register.

---
 rtl/clk_power_seq.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/clk_power_seq.sv
// ---------------------------------------------------------------------------
// clk_power_seq
//
// Power/clock sequencer for the external clock generator. It brings the
// oscillator up, qualifies it as stable, enables the clock, and holds the CPU
// in reset until the clock is good. It also sequences STOP mode: the clock is
// gated on a machine-cycle boundary, the oscillator is shut down, and a WAKE
// restarts everything without resetting the CPU (a "warm" start).
//
// Moore machine: every output is decoded from registered state only.
//
// Ports:
//   CLK         in   oscillator clock, all flops on rising edge
//   RESET       in   synchronous active-high reset
//   OSC_STABLE  in   oscillator-stable indication from the clock generator
//   M_ALIGN     in   one-cycle machine-cycle boundary strobe
//   STOP_REQ    in   CPU STOP request (level)
//   WAKE        in   wake event (level)
//   OSC_ENA     out  oscillator enable
//   CLK_ENA     out  clock enable
//   CPU_RESET   out  synchronous reset to the CPU core
//   FAULT       out  oscillator never qualified; sticky until RESET
//   WOKE        out  one-cycle pulse on the first RUN cycle after a warm wake
//   STATE       out  current state encoding (debug)
// ---------------------------------------------------------------------------
module clk_power_seq #(
   parameter int STABLE_CYCLES = 16,
   parameter int RESET_HOLD    = 4,
   parameter int TIMEOUT       = 1024
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       OSC_STABLE,
   input  logic       M_ALIGN,
   input  logic       STOP_REQ,
   input  logic       WAKE,
   output logic       OSC_ENA,
   output logic       CLK_ENA,
   output logic       CPU_RESET,
   output logic       FAULT,
   output logic       WOKE,
   output logic [2:0] STATE
);

   localparam int SW = $clog2(STABLE_CYCLES) + 1;
   localparam int TW = $clog2(TIMEOUT) + 1;
   localparam int HW = $clog2(RESET_HOLD) + 1;

   localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD - 1);

   localparam logic [2:0] ST_OFF         = 3'd0;
   localparam logic [2:0] ST_OSC_START   = 3'd1;
   localparam logic [2:0] ST_WAIT_STABLE = 3'd2;
   localparam logic [2:0] ST_CLK_ON      = 3'd3;
   localparam logic [2:0] ST_RUN         = 3'd4;
   localparam logic [2:0] ST_STOP_ALIGN  = 3'd5;
   localparam logic [2:0] ST_STOPPED     = 3'd6;
   localparam logic [2:0] ST_FAULT       = 3'd7;

   logic [2:0]    state_q, state_d;
   logic [SW-1:0] stab_q,  stab_d;
   logic [TW-1:0] to_q,    to_d;
   logic [HW-1:0] hold_q,  hold_d;
   logic          warm_q,  warm_d;

   // Next-state and counter logic. The hold counter is only meaningful in
   // CLK_ON, so it defaults to zero everywhere else and starts fresh on entry.
   // The warm flag remembers that we came out of STOPPED, so the restart skips
   // the CPU reset; it is consumed on the first RUN cycle.
   always_comb begin
      state_d = state_q;
      stab_d  = stab_q;
      to_d    = to_q;
      hold_d  = '0;
      warm_d  = warm_q;
      case (state_q)
         ST_OFF: begin
            state_d = ST_OSC_START;
         end
         ST_OSC_START: begin
            stab_d  = '0;
            to_d    = '0;
            state_d = ST_WAIT_STABLE;
         end
         ST_WAIT_STABLE: begin
            // Stability must be consecutive: any low sample restarts the count.
            stab_d = OSC_STABLE ? (stab_q + SW'(1)) : '0;
            to_d   = to_q + TW'(1);
            // Qualification is checked first so it wins over a coincident timeout.
            if (OSC_STABLE && (stab_q == STAB_LAST)) begin
               state_d = ST_CLK_ON;
            end else if (to_q == TO_LAST) begin
               state_d = ST_FAULT;
            end
         end
         ST_CLK_ON: begin
            if (warm_q) begin
               state_d = ST_RUN;
            end else begin
               hold_d = hold_q + HW'(1);
               if (hold_q == HOLD_LAST) begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            warm_d = 1'b0;
            // A STOP that coincides with a wake event is simply cancelled.
            if (STOP_REQ && !WAKE) begin
               state_d = ST_STOP_ALIGN;
            end
         end
         ST_STOP_ALIGN: begin
            if (WAKE) begin
               state_d = ST_RUN;
            end else if (M_ALIGN) begin
               state_d = ST_STOPPED;
            end
         end
         ST_STOPPED: begin
            warm_d = 1'b1;
            if (WAKE) begin
               state_d = ST_OSC_START;
            end
         end
         ST_FAULT: begin
            state_d = ST_FAULT;
         end
         default: begin
            state_d = ST_OFF;
         end
      endcase
   end

   // State and counter registers; RESET overrides everything.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= ST_OFF;
         stab_q  <= '0;
         to_q    <= '0;
         hold_q  <= '0;
         warm_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         stab_q  <= stab_d;
         to_q    <= to_d;
         hold_q  <= hold_d;
         warm_q  <= warm_d;
      end
   end

   // Output decode from registers only. While the oscillator comes up the
   // CPU reset keeps the value it had before: asserted on a cold start,
   // released on a warm restart, which is exactly the inverse of warm_q.
   always_comb begin
      OSC_ENA   = 1'b0;
      CLK_ENA   = 1'b0;
      CPU_RESET = 1'b0;
      FAULT     = 1'b0;
      WOKE      = 1'b0;
      case (state_q)
         ST_OFF: begin
            CPU_RESET = 1'b1;
         end
         ST_OSC_START, ST_WAIT_STABLE: begin
            OSC_ENA   = 1'b1;
            CPU_RESET = !warm_q;
         end
         ST_CLK_ON: begin
            OSC_ENA   = 1'b1;
            CLK_ENA   = 1'b1;
            CPU_RESET = !warm_q;
         end
         ST_RUN: begin
            OSC_ENA = 1'b1;
            CLK_ENA = 1'b1;
            WOKE    = warm_q;
         end
         ST_STOP_ALIGN: begin
            OSC_ENA = 1'b1;
            CLK_ENA = 1'b1;
         end
         ST_STOPPED: begin
            OSC_ENA = 1'b0;
         end
         ST_FAULT: begin
            CPU_RESET = 1'b1;
            FAULT     = 1'b1;
         end
         default: begin
            CPU_RESET = 1'b1;
         end
      endcase
   end

   assign STATE = state_q;

endmodule
